fp_align_addsub: RTL and testbench

FP_ALIGN_ADDSUB -- requirements
Module: fp_align_addsub

---
 rtl/fp_align_addsub_if.sv | 29 ++
 rtl/fp_align_addsub.sv | 153 +++++++++++++++
 tb/tb_fp_align_addsub.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_align_addsub_if.sv
// Handshake and operand/result bundle for the floating-point align/add-subtract front end.
// master drives operands and out_ready; slave is the datapath.
interface fp_align_addsub_if #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 op_sub;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic [EXP_BITS-1:0]  out_exp;
    logic [MANT_BITS+1:0] out_mant;
    logic                 out_special;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_special
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_special
    );
endinterface

// File: rtl/fp_align_addsub.sv
// IEEE-754 add/subtract front end: unpack/swap, align, add/subtract; result left unnormalized.
// Define FP_ADDSUB_SPECIALS_EN to detect NaN/Inf operands and flag them on out_special.
module fp_align_addsub #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23
) (
    input logic          clk,
    input logic          rst_n,
    fp_align_addsub_if.slave bus
);

    localparam int SIG_W = MANT_BITS + 1;
    localparam int SUM_W = MANT_BITS + 2;

    // Subnormals share the scale of exponent 1; their hidden bit is simply 0.
    function automatic logic [EXP_BITS-1:0] eff_exp(input logic [EXP_BITS-1:0] e);
        return (e == '0) ? EXP_BITS'(1) : e;
    endfunction

    function automatic logic [SIG_W-1:0] align_shift(input logic [SIG_W-1:0] m,
                                                      input logic [EXP_BITS-1:0] d);
        if (int'(d) >= SIG_W) return '0;
        return m >> d;
    endfunction

    logic ld_p0, ld_p1, ld_p2;
    logic vld_p0, vld_p1, vld_p2;

    logic [EXP_BITS-1:0] fld_a, fld_b, exp_a, exp_b;
    logic [SIG_W-1:0]    sig_a, sig_b;
    logic                sign_a, sign_b_eff, a_big;

    logic                sign_p0, eff_sub_p0;
    logic [EXP_BITS-1:0] exp_p0, diff_p0;
    logic [SIG_W-1:0]    big_p0, small_p0;

    logic                sign_p1, eff_sub_p1;
    logic [EXP_BITS-1:0] exp_p1;
    logic [SIG_W-1:0]    big_p1, small_p1;

    logic [SUM_W-1:0]    sum_s3;
    logic                sign_p2;
    logic [EXP_BITS-1:0] exp_p2;
    logic [SUM_W-1:0]    mant_p2;

    assign ld_p2        = !vld_p2 || bus.out_ready;
    assign ld_p1        = !vld_p1 || ld_p2;
    assign ld_p0        = !vld_p0 || ld_p1;
    assign bus.in_ready = ld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (ld_p0) vld_p0 <= bus.in_valid;
            if (ld_p1) vld_p1 <= vld_p0;
            if (ld_p2) vld_p2 <= vld_p1;
        end
    end

    // ---- S1: unpack, compare magnitudes, route larger/smaller ----
    assign fld_a      = bus.op_a[WIDTH-2 -: EXP_BITS];
    assign fld_b      = bus.op_b[WIDTH-2 -: EXP_BITS];
    assign exp_a      = eff_exp(fld_a);
    assign exp_b      = eff_exp(fld_b);
    assign sig_a      = {|fld_a, bus.op_a[MANT_BITS-1:0]};
    assign sig_b      = {|fld_b, bus.op_b[MANT_BITS-1:0]};
    assign sign_a     = bus.op_a[WIDTH-1];
    assign sign_b_eff = bus.op_b[WIDTH-1] ^ bus.op_sub;
    assign a_big      = {exp_a, sig_a} >= {exp_b, sig_b};

    always_ff @(posedge clk) begin
        if (ld_p0) begin
            eff_sub_p0 <= sign_a ^ sign_b_eff;
            sign_p0    <= a_big ? sign_a : sign_b_eff;
            exp_p0     <= a_big ? exp_a : exp_b;
            diff_p0    <= a_big ? (exp_a - exp_b) : (exp_b - exp_a);
            big_p0     <= a_big ? sig_a : sig_b;
            small_p0   <= a_big ? sig_b : sig_a;
        end
    end

    // ---- S2: align the smaller significand ----
    always_ff @(posedge clk) begin
        if (ld_p1) begin
            eff_sub_p1 <= eff_sub_p0;
            sign_p1    <= sign_p0;
            exp_p1     <= exp_p0;
            big_p1     <= big_p0;
            small_p1   <= align_shift(small_p0, diff_p0);
        end
    end

    // ---- S3: magnitude add/subtract; larger minus smaller never goes negative ----
    assign sum_s3 = eff_sub_p1 ? ({1'b0, big_p1} - {1'b0, small_p1})
                               : ({1'b0, big_p1} + {1'b0, small_p1});

`ifdef FP_ADDSUB_SPECIALS_EN
    localparam logic [SUM_W-1:0] NAN_MANT = SUM_W'(1) << (MANT_BITS - 1);

    logic a_nan, b_nan, a_inf, b_inf;
    logic spec_p0, nan_p0, spec_p1, nan_p1, spec_p2;

    assign a_inf = (fld_a == '1) && (bus.op_a[MANT_BITS-1:0] == '0);
    assign b_inf = (fld_b == '1) && (bus.op_b[MANT_BITS-1:0] == '0);
    assign a_nan = (fld_a == '1) && (bus.op_a[MANT_BITS-1:0] != '0);
    assign b_nan = (fld_b == '1) && (bus.op_b[MANT_BITS-1:0] != '0);

    always_ff @(posedge clk) begin
        if (ld_p0) begin
            spec_p0 <= (fld_a == '1) || (fld_b == '1);
            nan_p0  <= a_nan || b_nan || (a_inf && b_inf && (sign_a ^ sign_b_eff));
        end
        if (ld_p1) begin
            spec_p1 <= spec_p0;
            nan_p1  <= nan_p0;
        end
        if (ld_p2) begin
            spec_p2 <= spec_p1;
            if (spec_p1) begin
                sign_p2 <= sign_p1;
                exp_p2  <= '1;
                mant_p2 <= nan_p1 ? NAN_MANT : '0;
            end else begin
                sign_p2 <= (eff_sub_p1 && (sum_s3 == '0)) ? 1'b0 : sign_p1;
                exp_p2  <= exp_p1;
                mant_p2 <= sum_s3;
            end
        end
    end

    assign bus.out_special = vld_p2 && spec_p2;
`else
    always_ff @(posedge clk) begin
        if (ld_p2) begin
            sign_p2 <= (eff_sub_p1 && (sum_s3 == '0)) ? 1'b0 : sign_p1;
            exp_p2  <= exp_p1;
            mant_p2 <= sum_s3;
        end
    end

    assign bus.out_special = 1'b0;
`endif

    assign bus.out_valid = vld_p2;
    assign bus.out_sign  = vld_p2 && sign_p2;
    assign bus.out_exp   = vld_p2 ? exp_p2 : '0;
    assign bus.out_mant  = vld_p2 ? mant_p2 : '0;

endmodule

// File: tb/tb_fp_align_addsub.sv
// Bench for fp_align_addsub: directed vectors, randomized traffic against a reference model,
// backpressure, streaming and mid-flight reset.
module tb_fp_align_addsub;

    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [24:0] m;
        logic        sp;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fp_align_addsub_if #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23)) bus ();

    fp_align_addsub #(.WIDTH(32), .EXP_BITS(8), .MANT_BITS(23)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    res_t expq[$];
    logic acc, xfer, obs_valid, obs_in_ready;
    res_t obs;

    // Reference: real-number rules of the block, on plain integers.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        int unsigned fa, fb, ea, eb, ma, mb, e_big, m_big, m_small, d, al, r;
        logic sa, sb, s_big, esub, a_big;
        res_t o;
        fa = a[30:23];
        fb = b[30:23];
        ea = (fa == 0) ? 1 : fa;
        eb = (fb == 0) ? 1 : fb;
        ma = ((fa != 0) ? 32'h80_0000 : 0) + a[22:0];
        mb = ((fb != 0) ? 32'h80_0000 : 0) + b[22:0];
        sa = a[31];
        sb = b[31] ^ sub;
        esub = sa ^ sb;
        a_big = (ea > eb) || (ea == eb && ma >= mb);
        if (a_big) begin
            e_big = ea; m_big = ma; m_small = mb; d = ea - eb; s_big = sa;
        end else begin
            e_big = eb; m_big = mb; m_small = ma; d = eb - ea; s_big = sb;
        end
        al = (d >= 24) ? 0 : (m_small >> d);
        r = esub ? (m_big - al) : (m_big + al);
        o.s  = (esub && r == 0) ? 1'b0 : s_big;
        o.e  = e_big[7:0];
        o.m  = r[24:0];
        o.sp = 1'b0;
`ifdef FP_ADDSUB_SPECIALS_EN
        if (fa == 255 || fb == 255) begin
            o.sp = 1'b1;
            o.e  = 8'hFF;
            o.s  = s_big;
            o.m  = ((fa == 255 && a[22:0] != 0) || (fb == 255 && b[22:0] != 0) ||
                    (fa == 255 && fb == 255 && esub)) ? 25'h40_0000 : 25'h0;
        end
`endif
        return o;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0) v[30:23] = 8'($urandom_range(0, 2));
        return v;
    endfunction

    // Advance one cycle: sample at the falling edge, let the rising edge happen, return just after.
    task automatic step();
        @(negedge clk);
        acc          = bus.in_valid && bus.in_ready;
        xfer         = bus.out_valid && bus.out_ready;
        obs_valid    = bus.out_valid;
        obs_in_ready = bus.in_ready;
        obs          = {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_special};
        if (acc) expq.push_back(model(bus.op_a, bus.op_b, bus.op_sub));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1; bus.op_a = 32'h3F80_0000; bus.op_b = 32'h3F80_0000;
        bus.op_sub = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_sign !== 1'b0) begin failures++; $display("FAIL rst_out_sign: got %b want 0", bus.out_sign); end
        checks++; if (bus.out_exp !== 8'h0) begin failures++; $display("FAIL rst_out_exp: got %h want 0", bus.out_exp); end
        checks++; if (bus.out_mant !== 25'h0) begin failures++; $display("FAIL rst_out_mant: got %h want 0", bus.out_mant); end
        checks++; if (bus.out_special !== 1'b0) begin failures++; $display("FAIL rst_out_special: got %b want 0", bus.out_special); end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        checks++; if (obs_in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", obs_in_ready); end
        expq.delete();
    endtask

    task automatic test_directed();
        logic [31:0] a, b;
        logic        sub;
        res_t        want;
        int          lat;
        logic        got;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin a = 32'h3F80_0000; b = 32'h3F80_0000; sub = 1'b0; want = {1'b0, 8'd127, 25'h100_0000, 1'b0}; end
                1: begin a = 32'h3F80_0000; b = 32'h3F80_0000; sub = 1'b1; want = {1'b0, 8'd127, 25'h000_0000, 1'b0}; end
                2: begin a = 32'h4040_0000; b = 32'h40A0_0000; sub = 1'b1; want = {1'b1, 8'd129, 25'h040_0000, 1'b0}; end
                default: begin a = 32'h3F80_0000; b = 32'h3080_0000; sub = 1'b0; want = {1'b0, 8'd127, 25'h080_0000, 1'b0}; end
            endcase
            bus.op_a = a; bus.op_b = b; bus.op_sub = sub;
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            step();
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL dir%0d_accept: got %b want 1", k, acc); end
            bus.in_valid = 1'b0;
            got = 1'b0; lat = 0;
            for (int c = 1; c <= 8 && !got; c++) begin
                step();
                if (xfer) begin got = 1'b1; lat = c; end
            end
            checks++;
            if (!got) begin
                failures++; $display("FAIL dir%0d_timeout: no result within 8 cycles, want latency 3", k);
            end else begin
                if (lat != 3) begin failures++; $display("FAIL dir%0d_latency: got %0d want 3", k, lat); end
                checks++;
                if (obs !== want) begin
                    failures++;
                    $display("FAIL dir%0d_result: got s=%0b e=%0d m=%h sp=%0b want s=%0b e=%0d m=%h sp=%0b",
                             k, obs.s, obs.e, obs.m, obs.sp, want.s, want.e, want.m, want.sp);
                end
            end
            expq.delete();
        end
    endtask

    task automatic test_random();
        res_t held, want;
        logic held_v = 1'b0;
        logic [31:0] a, b;
        for (int i = 0; i < 400; i++) begin
            a = rand_fp();
            case ($urandom_range(0, 3))
                0: b = rand_fp();
                1: begin b = $urandom; b[30:23] = a[30:23]; end
                2: b = a;
                default: begin b = $urandom; b[30:23] = a[30:23] + 8'($urandom_range(0, 30)) - 8'd15; end
            endcase
            bus.op_a = a; bus.op_b = b; bus.op_sub = 1'($urandom);
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (held_v) begin
                checks++;
                if (!obs_valid || obs !== held) begin
                    failures++;
                    $display("FAIL rand_stall_stable: got v=%0b e=%0d m=%h want v=1 e=%0d m=%h",
                             obs_valid, obs.e, obs.m, held.e, held.m);
                end
            end
            held_v = obs_valid && !xfer;
            held   = obs;
            if (xfer) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++; $display("FAIL rand_unexpected: got e=%0d m=%h want no output", obs.e, obs.m);
                end else begin
                    want = expq.pop_front();
                    if (obs !== want) begin
                        failures++;
                        $display("FAIL rand_result: got s=%0b e=%0d m=%h sp=%0b want s=%0b e=%0d m=%h sp=%0b",
                                 obs.s, obs.e, obs.m, obs.sp, want.s, want.e, want.m, want.sp);
                    end
                end
            end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (xfer) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++; $display("FAIL rand_drain_extra: got e=%0d m=%h want no output", obs.e, obs.m);
                end else begin
                    want = expq.pop_front();
                    if (obs !== want) begin
                        failures++;
                        $display("FAIL rand_drain: got e=%0d m=%h want e=%0d m=%h", obs.e, obs.m, want.e, want.m);
                    end
                end
            end
        end
        checks++;
        if (expq.size() != 0) begin failures++; $display("FAIL rand_lost: got %0d pending want 0", expq.size()); end
        expq.delete();
    endtask

    task automatic test_back_to_back();
        int   n_acc = 0, n_out = 0, n_stream = 0;
        res_t held, want;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.op_a = rand_fp(); bus.op_b = rand_fp(); bus.op_sub = 1'($urandom);
            step();
            if (acc) n_acc++;
            if (i == 3) held = obs;
        end
        checks++; if (n_acc != 3) begin failures++; $display("FAIL b2b_accepts: got %0d want 3", n_acc); end
        checks++; if (obs_in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready: got %b want 0", obs_in_ready); end
        checks++;
        if (!obs_valid || obs !== held) begin
            failures++; $display("FAIL b2b_stable: got v=%0b m=%h want v=1 m=%h", obs_valid, obs.m, held.m);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (xfer) begin
                n_out++;
                checks++;
                want = (expq.size() != 0) ? expq.pop_front() : '0;
                if (obs !== want) begin
                    failures++;
                    $display("FAIL b2b_order: got e=%0d m=%h s=%0b want e=%0d m=%h s=%0b",
                             obs.e, obs.m, obs.s, want.e, want.m, want.s);
                end
            end
        end
        checks++; if (n_out != 3) begin failures++; $display("FAIL b2b_count: got %0d want 3", n_out); end
        expq.delete();

        n_acc = 0;
        for (int i = 0; i < 30 + 8; i++) begin
            bus.in_valid = (i < 30); bus.op_a = rand_fp(); bus.op_b = rand_fp(); bus.op_sub = 1'($urandom);
            step();
            if (acc) n_acc++;
            if (xfer) begin
                n_stream++;
                checks++;
                want = (expq.size() != 0) ? expq.pop_front() : '0;
                if (obs !== want) begin
                    failures++;
                    $display("FAIL stream_result: got e=%0d m=%h want e=%0d m=%h", obs.e, obs.m, want.e, want.m);
                end
            end
        end
        checks++; if (n_acc != 30) begin failures++; $display("FAIL stream_accepts: got %0d want 30", n_acc); end
        checks++; if (n_stream != 30) begin failures++; $display("FAIL stream_outputs: got %0d want 30", n_stream); end
        expq.delete();
    endtask

    task automatic test_reset_mid();
        int n_out = 0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.op_a = rand_fp(); bus.op_b = rand_fp(); bus.op_sub = 1'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_async: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_mant !== 25'h0) begin failures++; $display("FAIL midrst_mant: got %h want 0", bus.out_mant); end
        expq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (xfer) n_out++;
        end
        checks++; if (n_out != 0) begin failures++; $display("FAIL midrst_ghost: got %0d outputs want 0", n_out); end
    endtask

`ifdef FP_ADDSUB_SPECIALS_EN
    task automatic test_specials();
        logic got = 1'b0;
        bus.op_a = 32'h7F80_0000; bus.op_b = 32'hFF80_0000; bus.op_sub = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            step();
            if (xfer) got = 1'b1;
        end
        checks++;
        if (!got || obs.sp !== 1'b1 || obs.e !== 8'hFF || obs.m[22] !== 1'b1) begin
            failures++;
            $display("FAIL inf_minus_inf: got seen=%0b sp=%0b e=%h m=%h want sp=1 e=ff m[22]=1", got, obs.sp, obs.e, obs.m);
        end
        expq.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef FP_ADDSUB_SPECIALS_EN
        test_specials();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
